// File: rtl/delay_seq.sv
// Circular delay-line sequencer around a dual-port synchronous RAM.
// Output latency is two strobes-to-pulse; flush and rst return the block to IDLE.
module delay_seq #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic [ADDRESS_WIDTH-1:0] delay,
  input  logic [DATA_WIDTH-1:0]    sample_in,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic                     wr_en,
  output logic                     rd_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  output logic [DATA_WIDTH-1:0]    sample_out,
  output logic                     out_valid,
  output logic                     primed
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_wp;
  logic [ADDRESS_WIDTH-1:0] r_fill_cnt;
  logic [ADDRESS_WIDTH-1:0] w_fill_nxt;
  logic [ADDRESS_WIDTH-1:0] r_delay_q;
  logic [ADDRESS_WIDTH-1:0] w_delay_nxt;
  logic                     r_rd_pend;
  logic                     r_byp_vld;
  logic [DATA_WIDTH-1:0]    r_byp_dat;
  logic [DATA_WIDTH-1:0]    r_sample_out;
  logic                     r_out_valid;
  logic                     w_acc;
  logic                     w_byp;

  assign w_acc = en & ~flush;

  // Zero delay skips the RAM (read-during-write would be stale) and uses a
  // two-register pipe instead; the IDLE strobe itself already counts.
  assign w_byp = w_acc & (((r_state == S_IDLE) & (delay == '0)) |
                          ((r_state == S_RUN) & (r_delay_q == '0)));

  assign wr_en      = w_acc;
  assign wr_addr    = r_wp;
  assign ram_din    = sample_in;
  assign rd_en      = w_acc & (r_state == S_RUN) & (r_delay_q != '0);
  assign rd_addr    = r_wp - r_delay_q;
  assign sample_out = r_sample_out;
  assign out_valid  = r_out_valid;
  assign primed     = (r_state == S_RUN);

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill_cnt;
    w_delay_nxt = r_delay_q;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_delay_nxt = delay;
          w_fill_nxt  = ONE;
          w_state_nxt = (delay <= ONE) ? S_RUN : S_FILL;
        end
      end
      S_FILL: begin
        if (w_acc) begin
          w_fill_nxt = r_fill_cnt + ONE;
          if (r_fill_cnt == (r_delay_q - ONE)) begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wp         <= '0;
      r_fill_cnt   <= '0;
      r_delay_q    <= '0;
      r_rd_pend    <= 1'b0;
      r_byp_vld    <= 1'b0;
      r_byp_dat    <= '0;
      r_sample_out <= '0;
      r_out_valid  <= 1'b0;
    end else if (flush) begin
      r_state      <= S_IDLE;
      r_wp         <= '0;
      r_fill_cnt   <= '0;
      r_delay_q    <= '0;
      r_rd_pend    <= 1'b0;
      r_byp_vld    <= 1'b0;
      r_byp_dat    <= '0;
      r_sample_out <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_delay_q  <= w_delay_nxt;
      if (w_acc) begin
        r_wp <= r_wp + ONE;
      end
      r_rd_pend <= rd_en;
      r_byp_vld <= w_byp;
      if (w_byp) begin
        r_byp_dat <= sample_in;
      end
      r_out_valid <= r_rd_pend | r_byp_vld;
      if (r_rd_pend) begin
        r_sample_out <= ram_dout;
      end else if (r_byp_vld) begin
        r_sample_out <= r_byp_dat;
      end
    end
  end

endmodule
